// File: rtl/display_bbox_loader.sv
// Collects sanitised detection boxes, commits whole result sets atomically and
// replays exactly MAX_BBOX words to the overlay drawing stage on each frame start.
module display_bbox_loader #(
  parameter int FRAME_WIDTH  = 16,
  parameter int FRAME_HEIGHT = 9,
  parameter int MAX_BBOX     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] det_bbox_data,
  input  logic        det_bbox_valid,
  output logic        det_bbox_ready,
  input  logic        det_frame_done,
  input  logic        frame_start,
  output logic [63:0] bbox_data_out,
  output logic        bbox_data_out_valid,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(MAX_BBOX + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BBOX - 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_BBOX);
  localparam logic [15:0] XMAX = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] YMAX = 16'(FRAME_HEIGHT - 1);
  localparam logic [15:0] XLIM = 16'(FRAME_WIDTH);
  localparam logic [15:0] YLIM = 16'(FRAME_HEIGHT);
  localparam logic [63:0] NONE = '1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] idx;
  logic [CW-1:0] acc_cnt;
  logic          commit_pending;
  logic          accept;
  logic          start;
  logic          commit;
  logic [63:0]   acc       [MAX_BBOX];
  logic [63:0]   committed [MAX_BBOX];

  function automatic logic [63:0] sanitise(input logic [63:0] b);
    logic [15:0] x0, y0, x1, y1;
    {x0, y0, x1, y1} = b;
    if (x0 > x1 || y0 > y1 || x0 >= XLIM || y0 >= YLIM)
      return NONE;
    return {x0, y0, (x1 > XMAX) ? XMAX : x1, (y1 > YMAX) ? YMAX : y1};
  endfunction

  assign det_bbox_ready      = !commit_pending;
  assign accept              = det_bbox_valid && det_bbox_ready;
  assign busy                = (state == STREAM);
  assign bbox_data_out_valid = busy;
  assign bbox_data_out       = busy ? committed[idx] : '0;

  // frame_start wins over a pending commit; the commit waits for IDLE
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx = STREAM;
          start    = 1'b1;
        end else if (commit_pending) begin
          commit = 1'b1;
        end
      end
      STREAM: begin
        if (idx == LAST)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (start)
        idx <= '0;
      else if (busy)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt        <= '0;
      commit_pending <= 1'b0;
      drop_count     <= '0;
    end else begin
      if (commit)
        acc_cnt <= '0;
      else if (accept && acc_cnt != FULL)
        acc_cnt <= acc_cnt + 1'b1;
      if (accept && acc_cnt == FULL && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      // a done pulse while a commit is pending folds into that commit
      if (commit)
        commit_pending <= 1'b0;
      else if (det_frame_done)
        commit_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && acc_cnt != FULL)
      acc[acc_cnt] <= sanitise(det_bbox_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_BBOX; i++)
        committed[i] <= NONE;
    end else if (commit) begin
      for (int i = 0; i < MAX_BBOX; i++)
        committed[i] <= (CW'(i) < acc_cnt) ? acc[i] : NONE;
    end
  end

endmodule

// File: tb/tb_display_bbox_loader.sv
// Randomised bench for display_bbox_loader against a transaction-level
// model of result sets, sanitising and the per-frame replay.
module tb_display_bbox_loader;

  localparam int MB = 5;
  localparam int FW = 16;
  localparam int FH = 9;
  localparam logic [63:0] ONES = '1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] det_bbox_data = '0;
  logic        det_bbox_valid = 1'b0;
  logic        det_bbox_ready;
  logic        det_frame_done = 1'b0;
  logic        frame_start = 1'b0;
  logic [63:0] bbox_data_out;
  logic        bbox_data_out_valid;
  logic        busy;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  display_bbox_loader #(
    .FRAME_WIDTH(FW),
    .FRAME_HEIGHT(FH),
    .MAX_BBOX(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .det_bbox_data(det_bbox_data),
    .det_bbox_valid(det_bbox_valid),
    .det_bbox_ready(det_bbox_ready),
    .det_frame_done(det_frame_done),
    .frame_start(frame_start),
    .bbox_data_out(bbox_data_out),
    .bbox_data_out_valid(bbox_data_out_valid),
    .busy(busy),
    .drop_count(drop_count)
  );

  int checks = 0;
  int fails = 0;
  logic [63:0] q[$];
  logic [63:0] exp_set[MB];
  int exp_drop = 0;

  function automatic logic [63:0] ref_box(input logic [63:0] b);
    int x0, y0, x1, y1;
    logic [15:0] xc, yc;
    x0 = int'(b[63:48]);
    y0 = int'(b[47:32]);
    x1 = int'(b[31:16]);
    y1 = int'(b[15:0]);
    if (x0 > x1 || y0 > y1 || x0 >= FW || y0 >= FH)
      return ONES;
    xc = 16'((x1 < FW) ? x1 : FW - 1);
    yc = 16'((y1 < FH) ? y1 : FH - 1);
    return {b[63:32], xc, yc};
  endfunction

  function automatic logic [63:0] rnd_box();
    logic [15:0] c[4];
    for (int i = 0; i < 4; i++)
      c[i] = 16'($urandom_range(0, 20));
    if ($urandom_range(0, 7) == 0)
      c[0] = 16'hFFF0;
    return {c[0], c[1], c[2], c[3]};
  endfunction

  task automatic model_commit();
    for (int i = 0; i < MB; i++)
      exp_set[i] = (i < q.size()) ? q[i] : ONES;
    q.delete();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (det_bbox_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (det_bbox_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: ready=%b required 1", name, det_bbox_ready);
    end
  endtask

  task automatic send_box(input logic [63:0] b, input bit done);
    wait_ready("send_ready");
    det_bbox_valid = 1'b1;
    det_bbox_data  = b;
    det_frame_done = done;
    @(posedge clk);
    if (q.size() < MB)
      q.push_back(ref_box(b));
    else if (exp_drop < 255)
      exp_drop++;
    @(negedge clk);
    det_bbox_valid = 1'b0;
    det_frame_done = 1'b0;
  endtask

  task automatic do_commit();
    det_frame_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    det_frame_done = 1'b0;
    model_commit();
    wait_ready("commit_ready");
  endtask

  task automatic run_frame(input string name, input bit poke, input bit done, input bit rdy_low);
    frame_start    = 1'b1;
    det_frame_done = done;
    @(posedge clk);
    @(negedge clk);
    frame_start    = 1'b0;
    det_frame_done = 1'b0;
    for (int k = 0; k < MB; k++) begin
      checks++;
      if (bbox_data_out_valid !== 1'b1 || busy !== 1'b1 || bbox_data_out !== exp_set[k]) begin
        fails++;
        $display("FAIL %s word%0d: valid=%b busy=%b data=%h required 1 1 %h",
                 name, k, bbox_data_out_valid, busy, bbox_data_out, exp_set[k]);
      end
      if (rdy_low) begin
        checks++;
        if (det_bbox_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s ready_low%0d: ready=%b required 0", name, k, det_bbox_ready);
        end
      end
      frame_start = poke && (k == 1);
      @(negedge clk);
    end
    frame_start = 1'b0;
    checks++;
    if (bbox_data_out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s end: valid=%b busy=%b required 0 0", name, bbox_data_out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bbox_data_out !== 64'd0 || bbox_data_out_valid !== 1'b0 || busy !== 1'b0 ||
        drop_count !== 8'd0 || det_bbox_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b drop=%0d ready=%b required 0 0 0 0 1",
               bbox_data_out, bbox_data_out_valid, busy, drop_count, det_bbox_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < MB; i++)
      exp_set[i] = ONES;
    q.delete();
    exp_drop = 0;
    run_frame("reset_frame", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    send_box(64'h0001_0001_0005_0004, 1'b0);
    send_box(64'h0002_0000_0009_0008, 1'b1);
    model_commit();
    wait_ready("basic_ready");
    run_frame("basic_frame", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    send_box(64'h0003_0002_0014_0020, 1'b0);
    send_box(64'h0008_0000_0004_0003, 1'b0);
    do_commit();
    checks++;
    if (exp_set[0] !== 64'h0003_0002_000F_0008 || exp_set[1] !== ONES) begin
      fails++;
      $display("FAIL clamp_model: got %h %h required 0003_0002_000f_0008 ffff..",
               exp_set[0], exp_set[1]);
    end
    run_frame("clamp_frame", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++)
      send_box({16'(i), 16'(i), 16'(i + 2), 16'(i + 1)}, 1'b0);
    do_commit();
    checks++;
    if (drop_count !== 8'(exp_drop) || exp_drop != 2) begin
      fails++;
      $display("FAIL drop_2: drop=%0d required %0d", drop_count, exp_drop);
    end
    run_frame("overflow_frame", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      send_box(rnd_box(), 1'b0);
    checks++;
    if (drop_count !== 8'(exp_drop) || exp_drop != 255) begin
      fails++;
      $display("FAIL drop_sat: drop=%0d required %0d", drop_count, exp_drop);
    end
    do_commit();
    run_frame("sat_frame", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    send_box(64'h0004_0003_0006_0005, 1'b0);
    send_box(64'h0000_0000_000F_0008, 1'b0);
    run_frame("collide_old", 1'b0, 1'b1, 1'b1);
    checks++;
    if (det_bbox_ready !== 1'b0) begin
      fails++;
      $display("FAIL collide_commit_cycle: ready=%b required 0", det_bbox_ready);
    end
    @(negedge clk);
    checks++;
    if (det_bbox_ready !== 1'b1) begin
      fails++;
      $display("FAIL collide_ready_back: ready=%b required 1", det_bbox_ready);
    end
    model_commit();
    run_frame("collide_new", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++)
        send_box(rnd_box(), 1'b0);
      do_commit();
      run_frame("random_frame", r[0], 1'b0, 1'b0);
      checks++;
      if (drop_count !== 8'(exp_drop)) begin
        fails++;
        $display("FAIL random_drop: drop=%0d required %0d", drop_count, exp_drop);
      end
    end
  endtask

  task automatic test_reset_mid();
    send_box(64'h0001_0002_0003_0004, 1'b0);
    do_commit();
    frame_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bbox_data_out_valid !== 1'b1 || bbox_data_out !== exp_set[2]) begin
      fails++;
      $display("FAIL mid_word2: valid=%b data=%h required 1 %h",
               bbox_data_out_valid, bbox_data_out, exp_set[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bbox_data_out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_abort: valid=%b busy=%b required 0 0", bbox_data_out_valid, busy);
    end
    for (int i = 0; i < MB; i++)
      exp_set[i] = ONES;
    q.delete();
    exp_drop = 0;
    checks++;
    if (drop_count !== 8'd0 || det_bbox_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_state: drop=%0d ready=%b required 0 1", drop_count, det_bbox_ready);
    end
    run_frame("mid_after", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_overflow();
    test_collision();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
